// File: rtl/arbiter_pkg.sv
// Shared types for the instruction/data bus arbiter.
// The state encoding doubles as the externally visible owner code.
package arbiter_pkg;

   localparam logic [1:0] OWN_IDLE = 2'b00;
   localparam logic [1:0] OWN_I    = 2'b01;
   localparam logic [1:0] OWN_D    = 2'b10;

   localparam logic [3:0] BE_ALL   = 4'hF;

   typedef enum logic [1:0] {
      IDLE   = OWN_IDLE,
      I_XFER = OWN_I,
      D_XFER = OWN_D
   } arb_state_e;

endpackage

// File: rtl/generic_bus_arbiter.sv
// Two-master arbiter (instruction fetch, data) onto one generic bus; data has priority
// with a starvation limit, or round robin when ARB_ROUND_ROBIN_EN is defined.
//
// state  | meaning
// IDLE   | bus idle, arbitrate pending requests (one bubble after every transfer)
// I_XFER | instruction fetch owns the bus until busy=0 or i_ren drops
// D_XFER | data port owns the bus until busy=0 or d_ren/d_wen drop
module generic_bus_arbiter
   import arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        i_ren,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_busy,
   input  logic        d_ren,
   input  logic        d_wen,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byte_en,
   output logic [31:0] d_rdata,
   output logic        d_busy,
   output logic        ren,
   output logic        wen,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic [3:0]  byte_en,
   input  logic        busy,
   input  logic [31:0] rdata,
   output logic [1:0]  owner
);

   arb_state_e state_q, state_d;
   logic       i_req, d_req;
   logic       tie_grant_i;
   logic       grant_i, grant_d;

   assign i_req   = i_ren;
   assign d_req   = d_ren | d_wen;
   assign grant_i = (state_q == IDLE) && (state_d == I_XFER);
   assign grant_d = (state_q == IDLE) && (state_d == D_XFER);
   assign owner   = state_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q, last_d_d;

   // Flag resets to "last was I", so data wins the first tie.
   assign tie_grant_i = last_d_q;

   always_comb begin
      last_d_d = last_d_q;
      if (grant_i) last_d_d = 1'b0;
      else if (grant_d) last_d_d = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) last_d_q <= 1'b0;
      else     last_d_q <= last_d_d;
   end
`else
   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q, starve_d;

   assign tie_grant_i = (starve_q == LIMIT);

   // Counts data grants that overtook a waiting fetch; saturates at the limit.
   always_comb begin
      starve_d = starve_q;
      if (grant_i) starve_d = '0;
      else if (grant_d && i_ren && (starve_q != LIMIT)) starve_d = starve_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ren     = 1'b0;
      wen     = 1'b0;
      addr    = '0;
      wdata   = '0;
      byte_en = '0;
      i_busy  = 1'b1;
      d_busy  = 1'b1;
      i_rdata = '0;
      d_rdata = '0;
      case (state_q)
         IDLE: begin
            if (i_req && d_req) state_d = tie_grant_i ? I_XFER : D_XFER;
            else if (i_req)     state_d = I_XFER;
            else if (d_req)     state_d = D_XFER;
         end
         I_XFER: begin
            ren     = i_ren;
            addr    = i_addr;
            byte_en = BE_ALL;
            if (!busy) begin
               i_busy  = 1'b0;
               i_rdata = rdata;
            end
            if (!busy || !i_req) state_d = IDLE;
         end
         D_XFER: begin
            ren     = d_ren;
            wen     = d_wen;
            addr    = d_addr;
            wdata   = d_wdata;
            byte_en = d_byte_en;
            if (!busy) begin
               d_busy  = 1'b0;
               d_rdata = rdata;
            end
            if (!busy || !d_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Bench for generic_bus_arbiter: constant vector table, directed corner sequences,
// and random traffic compared against a transaction-level model.
`timescale 1ns/1ps
module tb_generic_bus_arbiter;

   localparam int SL = 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        i_ren, d_ren, d_wen, busy;
   logic [31:0] i_addr, d_addr, d_wdata, rdata;
   logic [3:0]  d_byte_en;
   logic [31:0] i_rdata, d_rdata, addr, wdata;
   logic        i_busy, d_busy, ren, wen;
   logic [3:0]  byte_en;
   logic [1:0]  owner;

   generic_bus_arbiter #(.STARVE_LIMIT(SL)) dut (
      .CLK(CLK), .RST(RST),
      .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy),
      .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_busy(d_busy),
      .ren(ren), .wen(wen), .addr(addr), .wdata(wdata), .byte_en(byte_en),
      .busy(busy), .rdata(rdata), .owner(owner)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [1:0]  owner;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  byte_en;
      logic        i_busy;
      logic [31:0] i_rdata;
      logic        d_busy;
      logic [31:0] d_rdata;
   } outs_t;

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr, dw;
      logic [31:0] da, dwd;
      logic [3:0]  dbe;
      logic        bz;
      logic [31:0] rd;
      outs_t       exp;
   } vec_t;

   int vectors = 0;
   int miscompares = 0;

   // Transaction-level model: who holds the bus (0 none, 1 fetch, 2 data),
   // how many data grants have jumped a waiting fetch, and who won last.
   int cur = 0;
   int hunger = 0;
   bit last_was_d = 1'b0;

   function automatic outs_t model_out();
      outs_t o;
      int    c;
      o = '0;
      o.i_busy = 1'b1;
      o.d_busy = 1'b1;
      c = RST ? 0 : cur;
      o.owner = 2'(c);
      if (c == 1) begin
         o.ren = i_ren; o.addr = i_addr; o.byte_en = 4'hF;
         if (!busy) begin o.i_busy = 1'b0; o.i_rdata = rdata; end
      end else if (c == 2) begin
         o.ren = d_ren; o.wen = d_wen; o.addr = d_addr; o.wdata = d_wdata;
         o.byte_en = d_byte_en;
         if (!busy) begin o.d_busy = 1'b0; o.d_rdata = rdata; end
      end
      return o;
   endfunction

   task automatic model_clock();
      bit want_i, want_d, dropped;
      int pick;
      if (RST) begin
         cur = 0; hunger = 0; last_was_d = 1'b0;
         return;
      end
      want_i = i_ren;
      want_d = d_ren | d_wen;
      if (cur != 0) begin
         dropped = (cur == 1) ? !want_i : !want_d;
         if (!busy || dropped) cur = 0;
         return;
      end
      pick = 0;
      if (want_i && want_d) begin
`ifdef ARB_ROUND_ROBIN_EN
         pick = last_was_d ? 1 : 2;
`else
         pick = (hunger >= SL) ? 1 : 2;
`endif
      end else if (want_i) pick = 1;
      else if (want_d) pick = 2;
      if (pick == 1) begin
         hunger = 0; last_was_d = 1'b0;
      end else if (pick == 2) begin
         if (want_i && hunger < SL) hunger++;
         last_was_d = 1'b1;
      end
      cur = pick;
   endtask

   function automatic outs_t actual();
      return {owner, ren, wen, addr, wdata, byte_en, i_busy, i_rdata, d_busy, d_rdata};
   endfunction

   // One clock: sample at negedge against the model, then advance the model at posedge.
   task automatic step(input string tag, output outs_t got);
      outs_t e;
      @(negedge CLK);
      got = actual();
      e = model_out();
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL %s @%0t: got=%h want=%h (owner %0d want %0d)", tag, $time, got, e,
                  got.owner, e.owner);
      end
      @(posedge CLK);
      model_clock();
      #1;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_ren = 0; i_addr = 0; d_ren = 0; d_wen = 0; d_addr = 0; d_wdata = 0;
      d_byte_en = 0; busy = 1; rdata = 0;
   endtask

   task automatic reset_dut();
      outs_t g;
      idle_inputs();
      RST = 1'b1;
      step("reset", g);
      RST = 1'b0;
   endtask

   function automatic vec_t mkv(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                                logic [31:0] dwd, logic [3:0] dbe, logic bz, logic [31:0] rd,
                                logic [1:0] eo, logic er, logic ew, logic [31:0] ea,
                                logic [31:0] ewd, logic [3:0] ebe, logic eib, logic [31:0] eir,
                                logic edb, logic [31:0] edr);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.dbe = dbe;
      v.bz = bz; v.rd = rd;
      v.exp = {eo, er, ew, ea, ewd, ebe, eib, eir, edb, edr};
      return v;
   endfunction

   initial begin
      vec_t  tbl[10];
      outs_t g;
      int    exp_own[14];
      localparam logic [31:0] IA = 32'h8000_0000;
      localparam logic [31:0] IB = 32'h8000_0004;

      // single fetch, then simultaneous write/fetch with the bubble in between
      tbl[0] = mkv(1, IA, 0, 0, 0, 0, 0, 1, 32'h13,   0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0);
      tbl[1] = mkv(1, IA, 0, 0, 0, 0, 0, 1, 32'h13,   1, 1, 0, IA, 0, 4'hF, 1, 0, 1, 0);
      tbl[2] = mkv(1, IA, 0, 0, 0, 0, 0, 0, 32'h13,   1, 1, 0, IA, 0, 4'hF, 0, 32'h13, 1, 0);
      tbl[3] = mkv(0, IA, 0, 0, 0, 0, 0, 1, 32'h13,   0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0);
      tbl[4] = mkv(1, IB, 0, 1, 32'h100, 32'hDEADBEEF, 4'h3, 1, 32'h55,
                   0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0);
      tbl[5] = mkv(1, IB, 0, 1, 32'h100, 32'hDEADBEEF, 4'h3, 1, 32'h55,
                   2, 0, 1, 32'h100, 32'hDEADBEEF, 4'h3, 1, 0, 1, 0);
      tbl[6] = mkv(1, IB, 0, 1, 32'h100, 32'hDEADBEEF, 4'h3, 0, 32'h55,
                   2, 0, 1, 32'h100, 32'hDEADBEEF, 4'h3, 1, 0, 0, 32'h55);
      tbl[7] = mkv(1, IB, 0, 0, 32'h100, 32'hDEADBEEF, 4'h3, 1, 32'h77,
                   0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0);
      tbl[8] = mkv(1, IB, 0, 0, 32'h100, 32'hDEADBEEF, 4'h3, 0, 32'h77,
                   1, 1, 0, IB, 0, 4'hF, 0, 32'h77, 1, 0);
      tbl[9] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 0,          0, 0, 0, 0, 0, 4'h0, 1, 0, 1, 0);

      idle_inputs();
      RST = 1'b1;
      #2;
      check_val("rst_owner", 32'(owner), 0);
      check_val("rst_busy", {30'd0, i_busy, d_busy}, 32'h3);
      check_val("rst_bus", {28'd0, ren, wen, 2'b00} | addr | wdata | i_rdata | d_rdata, 0);
      step("reset_hold", g);
      RST = 1'b0;

      for (int k = 0; k < 10; k++) begin
         i_ren = tbl[k].ir; i_addr = tbl[k].ia; d_ren = tbl[k].dr; d_wen = tbl[k].dw;
         d_addr = tbl[k].da; d_wdata = tbl[k].dwd; d_byte_en = tbl[k].dbe;
         busy = tbl[k].bz; rdata = tbl[k].rd;
         step($sformatf("tbl%0d_model", k), g);
         vectors++;
         if (g !== tbl[k].exp) begin
            miscompares++;
            $display("FAIL tbl%0d: got=%h want=%h", k, g, tbl[k].exp);
         end
      end

      // both requesters held, single-cycle transfers: grant order per arbitration mode
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = '{0, 2, 0, 1, 0, 2, 0, 1, 0, 2, 0, 1, 0, 2};
`else
      exp_own = '{0, 2, 0, 2, 0, 1, 0, 2, 0, 2, 0, 1, 0, 2};
`endif
      reset_dut();
      i_ren = 1; i_addr = IA; d_ren = 1; d_addr = 32'h40; busy = 0; rdata = 32'hA5A5_0001;
      for (int k = 0; k < 14; k++) begin
         step("starve", g);
         check_val($sformatf("starve_owner%0d", k), 32'(g.owner), exp_own[k]);
      end

      // reset asserted mid data transfer
      reset_dut();
      d_wen = 1; d_addr = 32'h300; d_wdata = 32'h1234_5678; d_byte_en = 4'hF; busy = 1;
      step("rst_mid_a", g);
      step("rst_mid_b", g);
      check_val("rst_mid_owner_before", 32'(g.owner), 2);
      #2;
      RST = 1'b1;
      #1;
      check_val("rst_mid_owner", 32'(owner), 0);
      check_val("rst_mid_wen", 32'(wen), 0);
      check_val("rst_mid_dbusy", 32'(d_busy), 1);
      busy = 0; rdata = 32'hFFFF_FFFF;
      #1;
      check_val("rst_mid_dbusy_cpl", 32'(d_busy), 1);
      check_val("rst_mid_drdata", d_rdata, 0);
      #1;
      step("rst_mid_c", g);
      RST = 1'b0;
      idle_inputs();
      step("rst_mid_d", g);

      // data drops its request mid transfer; waiting fetch follows after IDLE
      reset_dut();
      i_ren = 1; i_addr = IA; d_ren = 1; d_addr = 32'h200; busy = 1;
      step("drop_a", g);
      check_val("drop_owner_idle", 32'(g.owner), 0);
      step("drop_b", g);
      check_val("drop_owner_d", 32'(g.owner), 2);
      d_ren = 0;
      step("drop_c", g);
      check_val("drop_owner_d_dropped", 32'(g.owner), 2);
      check_val("drop_ren_follows", 32'(g.ren), 0);
      check_val("drop_dbusy", 32'(g.d_busy), 1);
      step("drop_d", g);
      check_val("drop_owner_bubble", 32'(g.owner), 0);
      step("drop_e", g);
      check_val("drop_owner_i", 32'(g.owner), 1);
      busy = 0; rdata = 32'h0BAD_F00D;
      step("drop_f", g);
      check_val("drop_i_cpl", {g.i_busy, g.i_rdata}, {1'b0, 32'h0BAD_F00D});

      // random traffic against the model
      idle_inputs();
      for (int n = 0; n < 3000; n++) begin
         RST       = ($urandom_range(0, 149) == 0);
         i_ren     = ($urandom_range(0, 2) != 0);
         i_addr    = $urandom;
         d_ren     = ($urandom_range(0, 2) == 0);
         d_wen     = ($urandom_range(0, 3) == 0);
         d_addr    = $urandom;
         d_wdata   = $urandom;
         d_byte_en = 4'($urandom);
         busy      = ($urandom_range(0, 2) != 0);
         rdata     = $urandom;
         step("random", g);
      end
      RST = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/generic_bus_arbiter.md
GENERIC_BUS_ARBITER -- requirements
Module: generic_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: maximum consecutive data grants while an instruction request waits.
REQ-002 SHALL have port CLK  input  1  core clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports i_ren  input  1, i_addr  input  32: instruction-fetch read request and address.
REQ-005 SHALL have ports i_rdata  output  32, i_busy  output  1: fetch read data and stall.
REQ-006 SHALL have ports d_ren  input  1, d_wen  input  1, d_addr  input  32, d_wdata  input  32, d_byte_en  input  4: data request.
REQ-007 SHALL have ports d_rdata  output  32, d_busy  output  1: data read data and stall.
REQ-008 SHALL have ports ren, wen  output  1, addr, wdata  output  32, byte_en  output  4: shared generic bus request.
REQ-009 SHALL have ports busy  input  1, rdata  input  32: shared generic bus response.
REQ-010 SHALL have port owner  output  2: current state encoding, 00 IDLE, 01 I_XFER, 10 D_XFER.

Function
REQ-011 SHALL implement FSM states IDLE, I_XFER, D_XFER.
REQ-012 SHALL deassert ren and wen and drive addr, wdata and byte_en to 0 in IDLE.
REQ-013 SHALL pass through the owner's request signals combinationally in I_XFER and D_XFER; I_XFER drives wen=0, wdata=0, byte_en=4'hF.
REQ-014 SHALL, in IDLE with exactly one request pending, enter that requester's XFER state at the next edge (one-cycle arbitration latency).
REQ-015 SHALL, in IDLE with both pending, grant data unless the starvation count equals STARVE_LIMIT, in which case it grants instruction.
REQ-016 SHALL keep a starvation counter: increments per D grant taken while i_ren is high, clears on any I grant, and saturates at STARVE_LIMIT.
REQ-017 SHALL treat completion as an XFER cycle with busy=0: that cycle forward rdata to the owner and drive the owner's busy to 0; next state is IDLE.
REQ-018 SHALL hold i_busy=1 and d_busy=1 in every cycle other than that requester's completion cycle.
REQ-019 SHALL drive i_rdata and d_rdata to rdata only in their completion cycle, and to 0 otherwise.
REQ-020 SHALL return to IDLE at the next edge if the owner drops its request before completion (protocol violation); the bus follows the dropped request.
REQ-021 SHALL start no new grant in the completion cycle, so there is always one IDLE bubble between transactions.

Reset
REQ-022 SHALL, on RST high and independent of CLK, force IDLE, clear the starvation count and last-grant flag, and drive owner=00, ren=wen=0, i_busy=d_busy=1, all data outputs 0.
REQ-023 SHALL abandon an in-flight transaction on reset with no completion signalled to either requester.

Configuration
REQ-024 SHALL support the macro ARB_ROUND_ROBIN_EN.
REQ-025 SHALL, with ARB_ROUND_ROBIN_EN defined, resolve simultaneous IDLE requests by granting the requester not granted last (last-grant flag reset to I, so D wins first), ignoring STARVE_LIMIT.
REQ-026 SHALL, without ARB_ROUND_ROBIN_EN, use the fixed data priority with starvation limit of REQ-015/REQ-016.

Structure
REQ-027 SHALL place the state enum (IDLE, I_XFER, D_XFER) and the owner encoding in the shared package arbiter_pkg.
REQ-028 SHALL contain no sub-module; the grant decision is a single combinational next-state block.

Verification
REQ-029 SHALL cover single fetch: i_ren=1, i_addr=0x80000000, busy low on third cycle, rdata=0x00000013 -> owner 01, i_rdata=0x00000013 with i_busy=0 in exactly that cycle.
REQ-030 SHALL cover simultaneous requests (fixed mode): i_ren=d_wen=1, d_addr=0x100, d_wdata=0xDEADBEEF, byte_en=4'h3 -> D granted first, bus wen=1, addr=0x100, byte_en=4'h3; I granted after the IDLE bubble.
REQ-031 SHALL cover starvation: d_ren continuously high, i_ren held, STARVE_LIMIT=2 -> two D grants, then an I grant, counter back to 0.
REQ-032 SHALL cover round robin (macro defined): both requesters held high -> grants alternate D,I,D,I.
REQ-033 SHALL cover reset mid-transfer: RST asserted during D_XFER with busy=1 -> same-cycle owner=00, wen=0, d_busy=1; no d_busy=0 pulse.
REQ-034 SHALL cover early drop: d_ren falls during D_XFER -> IDLE next edge, pending i_ren granted after.
